// File: rtl/matvec_engine_pkg.sv
// Shared definitions for the matrix-vector engine: FSM encoding, derived
// widths and the saturation limits of the signed fixed-point result.
package matvec_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ROUND = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  function automatic int calc_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int calc_addr_w(input int ncol);
    return (ncol <= 2) ? 1 : $clog2(ncol);
  endfunction

  // Full-precision products summed over NCOL columns plus a guard bit.
  function automatic int calc_acc_w(input int bw, input int ncol);
    return 2 * bw + $clog2(ncol) + 1;
  endfunction

  function automatic longint sat_max(input int bw);
    return (longint'(1) <<< (bw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int bw);
    return -(longint'(1) <<< (bw - 1));
  endfunction

endpackage

// File: rtl/matvec_engine_mac.sv
// One matrix row: multiply-accumulate over the columns, then bias, round
// half up, and saturate or wrap into the result register.
module mac_lane
  import matvec_engine_pkg::*;
#(
  parameter int NCOL     = 4,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int SATURATE = 1,
  parameter int BIAS_EN  = 1,
  localparam int BW      = calc_bitwidth(QN, QM)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic                 rnd_en,
  input  logic                 out_en,
  input  logic signed [BW-1:0] bias_in,
  input  logic signed [BW-1:0] weight,
  input  logic signed [BW-1:0] x_in,
  output logic signed [BW-1:0] result
);

  localparam int ACC_W = calc_acc_w(BW, NCOL);
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(BW));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(BW));

  logic signed [BW-1:0]    bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] rnd_q, rnd_d;
  logic signed [BW-1:0]    out_q, out_d;
  logic signed [2*BW-1:0]  prod;

  function automatic logic signed [SUM_W-1:0] round_half_up(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [BW-1:0]    bias
  );
    logic signed [SUM_W-1:0] b_ext;
    logic signed [SUM_W-1:0] half;
    logic signed [SUM_W-1:0] sum;
    b_ext = '0;
    if (BIAS_EN != 0) b_ext = SUM_W'(bias) <<< QM;
    half = SUM_W'(1) <<< (QM - 1);
    sum  = SUM_W'(acc) + b_ext + half;
    return sum >>> QM;
  endfunction

  function automatic logic signed [BW-1:0] clamp(input logic signed [SUM_W-1:0] v);
    logic signed [BW-1:0] r;
    r = $signed(v[BW-1:0]);
    if (SATURATE != 0) begin
      if (v > SAT_HI) r = $signed(SAT_HI[BW-1:0]);
      else if (v < SAT_LO) r = $signed(SAT_LO[BW-1:0]);
    end
    return r;
  endfunction

  assign prod = weight * x_in;

  always_comb begin
    bias_d = bias_q;
    acc_d  = acc_q;
    rnd_d  = rnd_q;
    out_d  = out_q;
    if (clr) begin
      bias_d = bias_in;
      acc_d  = '0;
    end else if (acc_en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    // Round stage first, clamp one cycle later into the visible result.
    if (rnd_en) rnd_d = round_half_up(acc_q, bias_q);
    if (out_en) out_d = clamp(rnd_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bias_q <= '0;
      acc_q  <= '0;
      rnd_q  <= '0;
      out_q  <= '0;
    end else begin
      bias_q <= bias_d;
      acc_q  <= acc_d;
      rnd_q  <= rnd_d;
      out_q  <= out_d;
    end
  end

  assign result = out_q;

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector engine: streams NCOL weight columns and vector elements,
// all NROW rows accumulate in parallel, result held until handshake.
module matvec_engine
  import matvec_engine_pkg::*;
#(
  parameter int NROW     = 32,
  parameter int NCOL     = 4,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int SATURATE = 1,
  parameter int BIAS_EN  = 1,
  localparam int BW      = calc_bitwidth(QN, QM),
  localparam int ADDR_W  = calc_addr_w(NCOL)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NROW*BW-1:0]   biasVec,
  output logic [ADDR_W-1:0]    colAddress,
  input  logic [NROW*BW-1:0]   weightCol,
  input  logic [BW-1:0]        inputVal,
  output logic                 busy,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [NROW*BW-1:0]   outputVec
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              out_valid_q, out_valid_d;
  logic              accept;
  logic              rnd_en;
  logic              out_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          accept  = 1'b1;
        end
      end
      ST_FETCH: begin
        if (cnt_q == ADDR_W'(NCOL - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_ROUND;
      ST_ROUND: state_d = ST_HOLD;
      ST_HOLD: begin
        // First HOLD cycle loads the clamped result; valid follows it.
        if (out_valid_q && outReady) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data returns one cycle after the address, so accumulate lags FETCH.
  assign vld_d  = (state_q == ST_FETCH);
  assign rnd_en = (state_q == ST_ROUND);
  assign out_en = (state_q == ST_HOLD) && !out_valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vld_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign colAddress = (state_q == ST_FETCH) ? cnt_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign outValid   = out_valid_q;

  for (genvar r = 0; r < NROW; r++) begin : g_lane
    mac_lane #(
      .NCOL     (NCOL),
      .QN       (QN),
      .QM       (QM),
      .SATURATE (SATURATE),
      .BIAS_EN  (BIAS_EN)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .clr     (accept),
      .acc_en  (vld_q),
      .rnd_en  (rnd_en),
      .out_en  (out_en),
      .bias_in (biasVec[r*BW +: BW]),
      .weight  (weightCol[r*BW +: BW]),
      .x_in    (inputVal),
      .result  (outputVec[r*BW +: BW])
    );
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: three builds (saturate, wrap, no bias)
// share stimulus and a registered weight/vector memory model.
module tb_matvec_engine;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int BW = 18;

  typedef struct packed {
    logic [NR-1:0][NC-1:0][BW-1:0] w;
    logic [NC-1:0][BW-1:0]         x;
    logic [NR-1:0][BW-1:0]         bias;
    logic [NR-1:0][BW-1:0]         exp_s;
    logic [NR-1:0][BW-1:0]         exp_w;
    logic [NR-1:0][BW-1:0]         exp_n;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              outReady = 1'b0;
  logic [NR*BW-1:0]  biasVec = '0;
  logic [NR*BW-1:0]  weightCol = '0;
  logic [BW-1:0]     inputVal = '0;
  logic [1:0]        col_a, col_b, col_c;
  logic              busy_a, busy_b, busy_c;
  logic              ov_a, ov_b, ov_c;
  logic [NR*BW-1:0]  out_a, out_b, out_c;
  vec_t              cur = '0;
  vec_t              vecs[6];
  int                checks = 0;
  int                failures = 0;

  always #5 clock = ~clock;

  matvec_engine #(.NROW(NR), .NCOL(NC), .QN(6), .QM(11), .SATURATE(1), .BIAS_EN(1)) dut (
    .clock(clock), .reset(reset), .start(start), .biasVec(biasVec), .colAddress(col_a),
    .weightCol(weightCol), .inputVal(inputVal), .busy(busy_a), .outValid(ov_a),
    .outReady(outReady), .outputVec(out_a));

  matvec_engine #(.NROW(NR), .NCOL(NC), .QN(6), .QM(11), .SATURATE(0), .BIAS_EN(1)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .biasVec(biasVec), .colAddress(col_b),
    .weightCol(weightCol), .inputVal(inputVal), .busy(busy_b), .outValid(ov_b),
    .outReady(outReady), .outputVec(out_b));

  matvec_engine #(.NROW(NR), .NCOL(NC), .QN(6), .QM(11), .SATURATE(1), .BIAS_EN(0)) dut_nb (
    .clock(clock), .reset(reset), .start(start), .biasVec(biasVec), .colAddress(col_c),
    .weightCol(weightCol), .inputVal(inputVal), .busy(busy_c), .outValid(ov_c),
    .outReady(outReady), .outputVec(out_c));

  // Weight RAM / vector source with one cycle of read latency.
  always @(posedge clock) begin
    for (int r = 0; r < NR; r++) weightCol[r*BW +: BW] <= cur.w[r][col_a];
    inputVal <= cur.x[col_a];
  end

  function automatic logic [BW-1:0] q18(input int v);
    return v[BW-1:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input vec_t v);
    cur = v;
    biasVec = v.bias;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy_a), 1);
    chk("col_addr_0", int'(col_a), 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ov_a && n < 40) begin
      tick();
      n++;
      if (n < NC) chk("col_addr_step", int'(col_a), n);
      else if (n == NC) chk("col_addr_idle", int'(col_a), 0);
    end
    if (!ov_a) chk("valid_timeout", 0, 1);
  endtask

  task automatic chk_rows(input string name, input logic [NR*BW-1:0] act,
                          input logic [NR-1:0][BW-1:0] exp);
    for (int r = 0; r < NR; r++)
      chk(name, int'($signed(act[r*BW +: BW])), int'($signed(exp[r])));
  endtask

  task automatic handshake;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("valid_drop", int'(ov_a), 0);
  endtask

  initial begin
    int n;
    bit seen;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // Identity weights, x = [1.0, 2.0, -1.5, 0.5]
    vecs[0].x[0] = q18(2048); vecs[0].x[1] = q18(4096);
    vecs[0].x[2] = q18(-3072); vecs[0].x[3] = q18(1024);
    for (int r = 0; r < NR; r++) begin
      vecs[0].w[r][r] = q18(2048);
      vecs[0].exp_s[r] = vecs[0].x[r];
    end
    vecs[0].exp_w = vecs[0].exp_s; vecs[0].exp_n = vecs[0].exp_s;
    // All 31.0 and all -31.0 weights against x = 31.0: +/-3844.0 overflows
    for (int c = 0; c < NC; c++) begin
      vecs[1].x[c] = q18(63488);
      vecs[4].x[c] = q18(63488);
      for (int r = 0; r < NR; r++) begin
        vecs[1].w[r][c] = q18(63488);
        vecs[4].w[r][c] = q18(-63488);
      end
    end
    for (int r = 0; r < NR; r++) begin
      vecs[1].exp_s[r] = q18(131071); vecs[1].exp_w[r] = q18(8192);
      vecs[1].exp_n[r] = q18(131071);
      vecs[4].exp_s[r] = q18(-131072); vecs[4].exp_w[r] = q18(-8192);
      vecs[4].exp_n[r] = q18(-131072);
    end
    // One LSB times 0.5: exactly half an LSB rounds up to 1
    vecs[2].x[0] = q18(1024);
    for (int r = 0; r < NR; r++) begin
      vecs[2].w[r][0] = q18(1);
      vecs[2].exp_s[r] = q18(1); vecs[2].exp_w[r] = q18(1); vecs[2].exp_n[r] = q18(1);
    end
    // Bias only
    vecs[3].bias[0] = q18(2048); vecs[3].bias[1] = q18(-2048);
    vecs[3].bias[2] = q18(0);    vecs[3].bias[3] = q18(512);
    vecs[3].exp_s = vecs[3].bias; vecs[3].exp_w = vecs[3].bias; vecs[3].exp_n = '0;
    // Negative and fractional rounding: -0.5 -> 0 (row0 is -1024/2048 -> 0), -1.0 LSB.. etc
    vecs[5].x[0] = q18(1024); vecs[5].x[1] = q18(1024);
    vecs[5].w[0][0] = q18(-1);
    vecs[5].w[1][0] = q18(-1); vecs[5].w[1][1] = q18(-1);
    vecs[5].w[2][0] = q18(3);
    vecs[5].w[3][0] = q18(1);  vecs[5].w[3][1] = q18(1);
    vecs[5].exp_s[0] = q18(0); vecs[5].exp_s[1] = q18(-1);
    vecs[5].exp_s[2] = q18(2); vecs[5].exp_s[3] = q18(1);
    vecs[5].exp_w = vecs[5].exp_s; vecs[5].exp_n = vecs[5].exp_s;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_valid", int'(ov_a), 0);
    chk("rst_col", int'(col_a), 0);
    chk("rst_out", int'(out_a != '0), 0);
    reset = 1'b1;

    // Table pass; each start lands the cycle after the previous handshake.
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i]);
      wait_valid(n);
      chk("latency", n, NC + 3);
      chk_rows("out_sat", out_a, vecs[i].exp_s);
      chk_rows("out_wrap", out_b, vecs[i].exp_w);
      chk_rows("out_nobias", out_c, vecs[i].exp_n);
      handshake();
    end

    // Back-pressure with start pulses in HOLD and in the handshake cycle.
    start_op(vecs[1]);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      chk("hold_valid", int'(ov_a), 1);
      chk_rows("hold_out", out_a, vecs[1].exp_s);
    end
    start = 1'b1;
    handshake();
    start = 1'b0;
    chk("idle_after_hs", int'(busy_a), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy_a || ov_a) seen = 1'b1;
    end
    chk("no_second_result", int'(seen), 0);

    // Abort in the middle of FETCH.
    start_op(vecs[0]);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_valid", int'(ov_a), 0);
    chk("abort_col", int'(col_a), 0);
    chk("abort_out", int'(out_a != '0), 0);
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov_a) seen = 1'b1;
    end
    chk("abort_no_valid", int'(seen), 0);
    start_op(vecs[5]);
    wait_valid(n);
    chk("latency_after_abort", n, NC + 3);
    chk_rows("out_after_abort", out_a, vecs[5].exp_s);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
